bus_reader: RTL and testbench
=============================

BUS_READER -- requirements
Module: bus_reader

Interface
REQ-001 Parameter DEPTH, default 4, sets the number of FIFO entries; legal values are 2, 4 and 8.
REQ-002 Parameter CW, default $clog2(DEPTH)+1, sets the width of the count output.
REQ-003 clk  input  1  sole clock; all state changes on its rising edge.
REQ-004 reset_n  input  1  asynchronous, active-low reset.
REQ-005 bus_in  input  8  shared 8-bit data bus, driven by a counter/register whose output enable is active.
REQ-006 load  input  1  capture strobe; high means bus_in holds a valid driven value this cycle.
REQ-007 rd_en  input  1  pop request from the consumer.
REQ-008 dout  output  8  head-of-FIFO data; first-word-fall-through.
REQ-009 valid  output  1  high when the FIFO is not empty, so dout is meaningful.
REQ-010 full  output  1  high when count equals DEPTH.
REQ-011 count  output  CW  number of occupied entries, 0..DEPTH.
REQ-012 overflow  output  1  sticky flag; high after a capture was dropped.
REQ-013 clr_ovf  input  1  synchronous clear for overflow.
REQ-014 last  output  8  most recent accepted captured value; holds between captures.

Function
REQ-015 Storage SHALL be a circular buffer of DEPTH x 8 bits with a write pointer, a read pointer and an occupancy count, all updated on the rising edge of clk.
REQ-016 load=1 with full=0 SHALL store bus_in at the write pointer, advance the pointer modulo DEPTH, and load bus_in into last, all in the same edge.
REQ-017 load=1 with full=1 and rd_en=0 SHALL drop the data, leave pointers, count and last unchanged, and set overflow at that edge.
REQ-018 load=1 with full=1 and rd_en=1 SHALL pop the head and accept the new word in the same edge, with no overflow; count stays DEPTH.
REQ-019 rd_en=1 with valid=1 SHALL advance the read pointer modulo DEPTH; the next entry SHALL appear on dout after that edge.
REQ-020 rd_en=1 with valid=0 SHALL be ignored, with no pointer change and no error flag.
REQ-021 load=1, rd_en=1 and count=0 SHALL perform the write only; valid rises after the edge.
REQ-022 load=1, rd_en=1 and 0<count<DEPTH SHALL perform both operations, leaving count unchanged.
REQ-023 count SHALL change by exactly +1, -1 or 0 per cycle and never leave the range 0..DEPTH.
REQ-024 Pointer wrap-around SHALL be seamless: DEPTH+1 sequential write/read pairs return data in exact order.
REQ-025 dout SHALL be driven combinationally from the entry at the read pointer; while valid=0 its value is don't-care but never X after reset, since storage resets to 0.
REQ-026 valid SHALL equal (count!=0) and full SHALL equal (count==DEPTH), both derived from registered count with no extra latency.
REQ-027 overflow SHALL stay high until clr_ovf=1; if clr_ovf and a new drop occur in the same cycle, overflow SHALL stay 1 (set wins).
REQ-028 load is sampled only at clk edges; the block SHALL not itself drive bus_in or any tristate net.

Reset
REQ-029 reset_n=0 SHALL immediately, without waiting for clk, clear pointers, count, overflow, last and all storage to 0, giving valid=0, full=0 and dout=0.
REQ-030 Reset asserted mid-operation SHALL discard all queued data; the first capture after release is stored at entry 0.
REQ-031 load and rd_en in the first clk edge after reset_n rises SHALL be honoured normally.

Verification
REQ-032 Reset, load 0x11, 0x22, 0x33 on consecutive cycles, then rd_en three cycles -> dout 0x11, 0x22, 0x33 in order; count 0->3->0; last=0x33.
REQ-033 DEPTH=4: load 0xA0..0xA4 on five cycles with rd_en=0 -> full=1 after the 4th; 0xA4 dropped; overflow=1; last=0xA3; drain returns 0xA0..0xA3.
REQ-034 Full FIFO, load 0x5A with rd_en=1 in the same cycle -> head popped, 0x5A accepted, count stays 4, overflow stays 0.
REQ-035 Empty FIFO, rd_en=1 alone -> no change; then load 0x7F with rd_en=1 -> count=1, dout=0x7F, valid=1.
REQ-036 Ten write/read pairs wrapping the pointers twice -> data order preserved; overflow set then clr_ovf=1 for one cycle -> overflow=0.
REQ-037 count=3, reset_n pulsed low between clock edges -> outputs zero before the next edge; after release, load 0x01 -> dout=0x01, count=1.

Source files
------------

// File: rtl/bus_reader.sv
// bus_reader: captures strobed values from a shared 8-bit bus into a small
// first-word-fall-through FIFO, tracks the last accepted capture and flags
// dropped captures with a sticky overflow bit.
module bus_reader #(
    parameter int DEPTH = 4,
    parameter int CW    = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic [7:0]    bus_in,
    input  logic          load,
    input  logic          rd_en,
    input  logic          clr_ovf,
    output logic [7:0]    dout,
    output logic          valid,
    output logic          full,
    output logic [CW-1:0] count,
    output logic          overflow,
    output logic [7:0]    last
);
    // DEPTH is a power of two, so pointers wrap naturally at AW bits
    localparam int AW = $clog2(DEPTH);

    logic [DEPTH-1:0][7:0] mem_q;
    logic [AW-1:0]         wptr_q, wptr_d;
    logic [AW-1:0]         rptr_q, rptr_d;
    logic [CW-1:0]         count_q, count_d;
    logic                  ovf_q, ovf_d;
    logic [7:0]            last_q, last_d;
    logic                  do_push, do_pop, drop;

    // status flags come straight from the registered count
    assign valid    = (count_q != '0);
    assign full     = (count_q == CW'(DEPTH));
    assign count    = count_q;
    assign overflow = ovf_q;
    assign last     = last_q;
    assign dout     = mem_q[rptr_q];

    // push/pop decision; a full FIFO still accepts when the head leaves in the same edge
    always_comb begin
        do_pop  = rd_en & valid;
        do_push = load & (~full | rd_en);
        drop    = load & full & ~rd_en;
        wptr_d  = do_push ? wptr_q + AW'(1) : wptr_q;
        rptr_d  = do_pop  ? rptr_q + AW'(1) : rptr_q;
        last_d  = do_push ? bus_in : last_q;
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
        // a new drop wins over a simultaneous clear
        if (drop)         ovf_d = 1'b1;
        else if (clr_ovf) ovf_d = 1'b0;
        else              ovf_d = ovf_q;
    end

    // control state
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
            last_q  <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
            ovf_q   <= ovf_d;
            last_q  <= last_d;
        end
    end

    // storage; cleared on reset so dout is never X even while empty
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mem_q <= '0;
        end else if (do_push) begin
            mem_q[wptr_q] <= bus_in;
        end
    end

endmodule

// File: tb/tb_bus_reader.sv
// Bench for bus_reader: queue-based reference model, per-cycle compare
// process, directed scenarios with literal expectations, random traffic.
module tb_bus_reader;
    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic [7:0]    bus_in = '0;
    logic          load = 1'b0;
    logic          rd_en = 1'b0;
    logic          clr_ovf = 1'b0;
    logic [7:0]    dout;
    logic          valid;
    logic          full;
    logic [CW-1:0] count;
    logic          overflow;
    logic [7:0]    last;

    int errors = 0;
    int checks = 0;

    // reference model state
    logic [7:0] m_q[$];
    logic [7:0] m_last = '0;
    logic       m_ovf  = 1'b0;

    bus_reader #(.DEPTH(DEPTH)) dut (
        .clk(clk), .reset_n(reset_n), .bus_in(bus_in), .load(load),
        .rd_en(rd_en), .clr_ovf(clr_ovf), .dout(dout), .valid(valid),
        .full(full), .count(count), .overflow(overflow), .last(last)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        m_last = '0;
        m_ovf  = 1'b0;
    endtask

    // one clock: drive inputs, take the edge, advance the model by the rules
    task automatic step(input logic l, input logic [7:0] b, input logic r, input logic c);
        bit pop_ok, push_ok;
        load = l; bus_in = b; rd_en = r; clr_ovf = c;
        @(posedge clk);
        pop_ok  = r && (m_q.size() > 0);
        push_ok = l && (m_q.size() < DEPTH || r);
        if (pop_ok) void'(m_q.pop_front());
        if (push_ok) begin
            m_q.push_back(b);
            m_last = b;
        end
        if (l && !push_ok) m_ovf = 1'b1;
        else if (c)        m_ovf = 1'b0;
        #1;
        load = 1'b0; rd_en = 1'b0; clr_ovf = 1'b0;
    endtask

    // every cycle: DUT outputs against the model, away from the active edge
    always @(negedge clk) begin
        chk("count", int'(count), m_q.size());
        chk("valid", int'(valid), int'(m_q.size() != 0));
        chk("full", int'(full), int'(m_q.size() == DEPTH));
        chk("overflow", int'(overflow), int'(m_ovf));
        chk("last", int'(last), int'(m_last));
        if (m_q.size() != 0) chk("dout", int'(dout), int'(m_q[0]));
    end

    initial begin
        model_reset();
        repeat (2) @(posedge clk);
        #3;
        chk("rst_dout", int'(dout), 0);
        chk("rst_valid", int'(valid), 0);
        chk("rst_full", int'(full), 0);
        reset_n = 1'b1;
        #1;

        // three captures then three pops
        step(1, 8'h11, 0, 0);
        step(1, 8'h22, 0, 0);
        step(1, 8'h33, 0, 0);
        chk("lit_cnt3", int'(count), 3);
        chk("lit_last33", int'(last), 8'h33);
        chk("lit_head11", int'(dout), 8'h11);
        step(0, 0, 1, 0);
        chk("lit_head22", int'(dout), 8'h22);
        step(0, 0, 1, 0);
        chk("lit_head33", int'(dout), 8'h33);
        step(0, 0, 1, 0);
        chk("lit_cnt0", int'(count), 0);

        // overfill: fifth capture dropped
        for (int i = 0; i < 5; i++) begin
            step(1, 8'hA0 + 8'(i), 0, 0);
            if (i == 3) chk("lit_full4", int'(full), 1);
        end
        chk("lit_ovf", int'(overflow), 1);
        chk("lit_lastA3", int'(last), 8'hA3);

        // simultaneous load+pop while full: no overflow change, count stays 4
        step(0, 0, 0, 1);
        chk("lit_ovf_clr", int'(overflow), 0);
        step(1, 8'h5A, 1, 0);
        chk("lit_full_cnt", int'(count), 4);
        chk("lit_full_ovf", int'(overflow), 0);
        chk("lit_full_head", int'(dout), 8'hA1);

        // drop and clear together: set wins
        step(1, 8'hEE, 0, 1);
        chk("lit_setwins", int'(overflow), 1);

        // drain, checking order A1 A2 A3 5A
        for (int i = 0; i < 4; i++) step(0, 0, 1, 0);
        chk("lit_drained", int'(valid), 0);

        // pop on empty ignored, then load+pop on empty writes only
        step(0, 0, 1, 0);
        chk("lit_empty_rd", int'(count), 0);
        step(1, 8'h7F, 1, 0);
        chk("lit_7f_cnt", int'(count), 1);
        chk("lit_7f_dout", int'(dout), 8'h7F);
        chk("lit_7f_valid", int'(valid), 1);
        step(0, 0, 1, 0);

        // ten write/read pairs wrap the pointers
        for (int i = 0; i < 10; i++) begin
            step(1, 8'(8'h30 + i), 0, 0);
            chk("lit_wrap", int'(dout), 8'h30 + i);
            step(0, 0, 1, 0);
        end
        step(0, 0, 0, 1);
        chk("lit_ovf_clr2", int'(overflow), 0);

        // reset between edges with three entries queued
        step(1, 8'h01, 0, 0);
        step(1, 8'h02, 0, 0);
        step(1, 8'h03, 0, 0);
        #1;
        reset_n = 1'b0;
        model_reset();
        #1;
        chk("mid_rst_cnt", int'(count), 0);
        chk("mid_rst_dout", int'(dout), 0);
        chk("mid_rst_valid", int'(valid), 0);
        chk("mid_rst_last", int'(last), 0);
        reset_n = 1'b1;
        step(1, 8'h01, 0, 0);
        chk("post_rst_dout", int'(dout), 8'h01);
        chk("post_rst_cnt", int'(count), 1);

        // randomized traffic in fill-biased and drain-biased phases
        for (int p = 0; p < 8; p++) begin
            for (int i = 0; i < 60; i++) begin
                int lp, rp;
                lp = (p % 2 == 0) ? 75 : 30;
                rp = (p % 2 == 0) ? 30 : 75;
                step(($urandom_range(99) < lp), 8'($urandom),
                     ($urandom_range(99) < rp), ($urandom_range(99) < 10));
            end
        end

        @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end
endmodule
